// File: rtl/clk_rst_sequencer.sv
// Power-up / recovery sequencer: MMCM reset, lock supervision with bounded retry,
// OV7670 PWDN/RESET sequencing, then release of the system reset.
module clk_rst_sequencer #(
   parameter int MMCM_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT    = 100000,
   parameter int CAM_RST_CYCLES  = 100000,
   parameter int CAM_WAKE_CYCLES = 100000,
   parameter int MAX_RETRY       = 3,
   parameter int CNT_W           = 20
) (
   input  logic       CLK_100,
   input  logic       reset_n,
   input  logic       locked,
   input  logic       restart,
   output logic       mmcm_reset,
   output logic       cam_pwdn,
   output logic       cam_reset_n,
   output logic       sys_rst_n,
   output logic       ready,
   output logic       fault,
   output logic [3:0] retry_cnt,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_RST_MMCM  = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_CAM_RST   = 3'd2,
      S_CAM_WAKE  = 3'd3,
      S_RUN       = 3'd4,
      S_FAULT     = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] MMCM_LAST = CNT_W'(MMCM_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CRST_LAST = CNT_W'(CAM_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(CAM_WAKE_CYCLES - 1);
   localparam logic [3:0]       MAX_R     = 4'(MAX_RETRY);

   state_t           cur;
   state_t           nxt;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       retry_nxt;
   logic [3:0]       retry_inc;
   logic             locked_m;
   logic             locked_s;

   assign state     = cur;
   assign retry_inc = (retry_cnt >= MAX_R) ? MAX_R : 4'(retry_cnt + 4'd1);

   always_comb begin
      nxt       = cur;
      retry_nxt = retry_cnt;
      if (restart) begin
         nxt       = S_RST_MMCM;
         retry_nxt = 4'd0;
      end else begin
         case (cur)
            S_RST_MMCM:  if (cnt == MMCM_LAST) nxt = S_WAIT_LOCK;
            // Lock seen on the timeout cycle still counts as a successful attempt.
            S_WAIT_LOCK: begin
               if (locked_s) begin
                  nxt = S_CAM_RST;
               end else if (cnt == LOCK_LAST) begin
                  retry_nxt = retry_inc;
                  nxt       = (retry_inc == MAX_R) ? S_FAULT : S_RST_MMCM;
               end
            end
            S_CAM_RST: begin
               if (!locked_s)              nxt = S_RST_MMCM;
               else if (cnt == CRST_LAST)  nxt = S_CAM_WAKE;
            end
            S_CAM_WAKE: begin
               if (!locked_s) begin
                  nxt = S_RST_MMCM;
               end else if (cnt == WAKE_LAST) begin
                  nxt       = S_RUN;
                  retry_nxt = 4'd0;
               end
            end
            S_RUN:   if (!locked_s) nxt = S_RST_MMCM;
            S_FAULT: nxt = S_FAULT;
            default: nxt = S_RST_MMCM;
         endcase
      end
   end

   always_ff @(posedge CLK_100 or negedge reset_n) begin
      if (!reset_n) begin
         locked_m    <= 1'b0;
         locked_s    <= 1'b0;
         cur         <= S_RST_MMCM;
         cnt         <= '0;
         retry_cnt   <= 4'd0;
         mmcm_reset  <= 1'b1;
         cam_pwdn    <= 1'b1;
         cam_reset_n <= 1'b0;
         sys_rst_n   <= 1'b0;
         ready       <= 1'b0;
         fault       <= 1'b0;
      end else begin
         locked_m  <= locked;
         locked_s  <= locked_m;
         cur       <= nxt;
         retry_cnt <= retry_nxt;
         // A restart re-arms the RST_MMCM dwell even if already in that state.
         cnt       <= (nxt != cur || restart) ? '0 : cnt + CNT_W'(1);
         case (nxt)
            S_WAIT_LOCK: {mmcm_reset, cam_pwdn, cam_reset_n, sys_rst_n, ready, fault} <= 6'b010000;
            S_CAM_RST:   {mmcm_reset, cam_pwdn, cam_reset_n, sys_rst_n, ready, fault} <= 6'b000000;
            S_CAM_WAKE:  {mmcm_reset, cam_pwdn, cam_reset_n, sys_rst_n, ready, fault} <= 6'b001000;
            S_RUN:       {mmcm_reset, cam_pwdn, cam_reset_n, sys_rst_n, ready, fault} <= 6'b001110;
            S_FAULT:     {mmcm_reset, cam_pwdn, cam_reset_n, sys_rst_n, ready, fault} <= 6'b110001;
            default:     {mmcm_reset, cam_pwdn, cam_reset_n, sys_rst_n, ready, fault} <= 6'b110000;
         endcase
      end
   end

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Directed bench for clk_rst_sequencer with short dwell parameters.
module tb_clk_rst_sequencer;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       locked = 1'b0;
   logic       restart = 1'b0;
   logic       mmcm_reset, cam_pwdn, cam_reset_n, sys_rst_n, ready, fault;
   logic [3:0] retry_cnt;
   logic [2:0] state;
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   clk_rst_sequencer #(
      .MMCM_RST_CYCLES(4), .LOCK_TIMEOUT(20), .CAM_RST_CYCLES(8),
      .CAM_WAKE_CYCLES(10), .MAX_RETRY(3), .CNT_W(8)
   ) dut (
      .CLK_100(clk), .reset_n(reset_n), .locked(locked), .restart(restart),
      .mmcm_reset(mmcm_reset), .cam_pwdn(cam_pwdn), .cam_reset_n(cam_reset_n),
      .sys_rst_n(sys_rst_n), .ready(ready), .fault(fault),
      .retry_cnt(retry_cnt), .state(state)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Outputs packed as mmcm_reset/cam_pwdn/cam_reset_n/sys_rst_n/ready/fault.
   function automatic logic [5:0] outs();
      return {mmcm_reset, cam_pwdn, cam_reset_n, sys_rst_n, ready, fault};
   endfunction

   task automatic test_reset();
      reset_n = 1'b0; locked = 1'b0; restart = 1'b0;
      repeat (3) tick();
      checks++;
      if (outs() !== 6'b110000) begin
         errors++; $display("FAIL reset_outs: got %b expected 110000", outs());
      end
      checks++;
      if (state !== 3'd0 || retry_cnt !== 4'd0) begin
         errors++; $display("FAIL reset_state: got state=%0d retry=%0d expected 0/0", state, retry_cnt);
      end
      reset_n = 1'b1;
   endtask

   // Runs from CAM_RST entry (state just became 2) through to RUN.
   task automatic cam_seq(input string tag);
      for (int i = 0; i < 7; i++) begin
         tick();
         checks++;
         if (state !== 3'd2 || cam_reset_n !== 1'b0) begin
            errors++; $display("FAIL %s cam_rst_hold%0d: got state=%0d cam_reset_n=%b expected 2/0", tag, i, state, cam_reset_n);
         end
      end
      tick();
      checks++;
      if (state !== 3'd3 || outs() !== 6'b001000) begin
         errors++; $display("FAIL %s cam_wake_entry: got state=%0d outs=%b expected 3/001000", tag, state, outs());
      end
      for (int i = 0; i < 9; i++) begin
         tick();
         checks++;
         if (ready !== 1'b0 || sys_rst_n !== 1'b0) begin
            errors++; $display("FAIL %s wake_hold%0d: got ready=%b sys_rst_n=%b expected 0/0", tag, i, ready, sys_rst_n);
         end
      end
      tick();
      checks++;
      if (state !== 3'd4 || outs() !== 6'b001110 || retry_cnt !== 4'd0) begin
         errors++; $display("FAIL %s run_entry: got state=%0d outs=%b retry=%0d expected 4/001110/0", tag, state, outs(), retry_cnt);
      end
   endtask

   // Bring-up from RST_MMCM entry with locked low; lock raised 5 cycles after mmcm_reset falls.
   task automatic bring_up(input string tag);
      for (int i = 1; i <= 4; i++) begin
         tick();
         checks++;
         if (mmcm_reset !== (i < 4)) begin
            errors++; $display("FAIL %s mmcm_pulse%0d: got %b expected %b", tag, i, mmcm_reset, (i < 4));
         end
      end
      checks++;
      if (state !== 3'd1) begin
         errors++; $display("FAIL %s wait_lock_entry: got %0d expected 1", tag, state);
      end
      repeat (5) tick();
      locked = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (state !== 3'd1) begin
            errors++; $display("FAIL %s lock_sync%0d: got state=%0d expected 1", tag, i, state);
         end
      end
      tick();
      checks++;
      if (state !== 3'd2 || cam_pwdn !== 1'b0) begin
         errors++; $display("FAIL %s cam_rst_entry: got state=%0d cam_pwdn=%b expected 2/0", tag, state, cam_pwdn);
      end
      cam_seq(tag);
   endtask

   // Bring-up from RST_MMCM entry with locked_s already high.
   task automatic quick_up(input string tag);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (state !== 3'd0 || mmcm_reset !== 1'b1) begin
            errors++; $display("FAIL %s rst_hold%0d: got state=%0d mmcm=%b expected 0/1", tag, i, state, mmcm_reset);
         end
      end
      tick();
      checks++;
      if (state !== 3'd1) begin
         errors++; $display("FAIL %s wait_entry: got %0d expected 1", tag, state);
      end
      tick();
      checks++;
      if (state !== 3'd2) begin
         errors++; $display("FAIL %s cam_entry: got %0d expected 2", tag, state);
      end
      cam_seq(tag);
   endtask

   task automatic test_nominal();
      bring_up("nominal");
   endtask

   task automatic test_no_lock();
      reset_n = 1'b0; locked = 1'b0;
      tick();
      reset_n = 1'b1;
      for (int a = 1; a <= 3; a++) begin
         repeat (4) tick();
         checks++;
         if (state !== 3'd1) begin
            errors++; $display("FAIL nolock_wait%0d: got %0d expected 1", a, state);
         end
         repeat (19) tick();
         checks++;
         if (state !== 3'd1 || retry_cnt !== 4'(a - 1)) begin
            errors++; $display("FAIL nolock_dwell%0d: got state=%0d retry=%0d expected 1/%0d", a, state, retry_cnt, a - 1);
         end
         tick();
         checks++;
         if (retry_cnt !== 4'(a) || state !== ((a == 3) ? 3'd5 : 3'd0)) begin
            errors++; $display("FAIL nolock_expire%0d: got state=%0d retry=%0d expected %0d/%0d", a, state, retry_cnt, (a == 3) ? 5 : 0, a);
         end
      end
      repeat (6) tick();
      checks++;
      if (state !== 3'd5 || outs() !== 6'b110001 || retry_cnt !== 4'd3) begin
         errors++; $display("FAIL fault_hold: got state=%0d outs=%b retry=%0d expected 5/110001/3", state, outs(), retry_cnt);
      end
      restart = 1'b1;
      tick();
      restart = 1'b0;
      checks++;
      if (state !== 3'd0 || fault !== 1'b0 || retry_cnt !== 4'd0 || mmcm_reset !== 1'b1) begin
         errors++; $display("FAIL fault_restart: got state=%0d fault=%b retry=%0d mmcm=%b expected 0/0/0/1", state, fault, retry_cnt, mmcm_reset);
      end
      bring_up("post_fault");
   endtask

   task automatic test_lock_loss();
      locked = 1'b0;
      tick();
      locked = 1'b1;
      tick();
      checks++;
      if (ready !== 1'b1) begin
         errors++; $display("FAIL loss_early: got ready=%b expected 1", ready);
      end
      tick();
      checks++;
      if (ready !== 1'b0 || sys_rst_n !== 1'b0 || mmcm_reset !== 1'b1 || state !== 3'd0 || retry_cnt !== 4'd0) begin
         errors++; $display("FAIL loss_react: got ready=%b sys=%b mmcm=%b state=%0d retry=%0d expected 0/0/1/0/0", ready, sys_rst_n, mmcm_reset, state, retry_cnt);
      end
      quick_up("reseq");
   endtask

   task automatic test_lock_on_timeout();
      reset_n = 1'b0; locked = 1'b0;
      tick();
      reset_n = 1'b1;
      repeat (4) tick();
      repeat (17) tick();
      locked = 1'b1;
      tick();
      tick();
      checks++;
      if (state !== 3'd1) begin
         errors++; $display("FAIL timeout_pre: got %0d expected 1", state);
      end
      tick();
      checks++;
      if (state !== 3'd2 || retry_cnt !== 4'd0) begin
         errors++; $display("FAIL lock_on_timeout: got state=%0d retry=%0d expected 2/0", state, retry_cnt);
      end
   endtask

   task automatic test_async_reset();
      repeat (8) tick();
      checks++;
      if (state !== 3'd3) begin
         errors++; $display("FAIL wake_reached: got %0d expected 3", state);
      end
      repeat (3) tick();
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (outs() !== 6'b110000 || state !== 3'd0 || retry_cnt !== 4'd0) begin
         errors++; $display("FAIL async_reset: got outs=%b state=%0d retry=%0d expected 110000/0/0", outs(), state, retry_cnt);
      end
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_restart();
      quick_up("after_reset");
      restart = 1'b1;
      tick();
      restart = 1'b0;
      checks++;
      if (state !== 3'd0 || mmcm_reset !== 1'b1 || ready !== 1'b0) begin
         errors++; $display("FAIL restart_run: got state=%0d mmcm=%b ready=%b expected 0/1/0", state, mmcm_reset, ready);
      end
      quick_up("after_restart");
      restart = 1'b1; locked = 1'b0;
      tick();
      restart = 1'b0;
      checks++;
      if (state !== 3'd0 || retry_cnt !== 4'd0 || mmcm_reset !== 1'b1) begin
         errors++; $display("FAIL restart_and_loss: got state=%0d retry=%0d mmcm=%b expected 0/0/1", state, retry_cnt, mmcm_reset);
      end
      repeat (3) tick();
      tick();
      checks++;
      if (state !== 3'd1 || retry_cnt !== 4'd0) begin
         errors++; $display("FAIL restart_then_wait: got state=%0d retry=%0d expected 1/0", state, retry_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_no_lock();
      test_lock_loss();
      test_lock_on_timeout();
      test_async_reset();
      test_restart();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
